dec_bin_seq: RTL and testbench
==============================

// Module: dec_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter; reverse path of the binary-to-decimal digit extractors.
//  Converts a DIGITS-digit packed BCD value (MSD in top nibble) to unsigned binary.
//  Works one digit per clock, MSD first: acc <= acc*10 + digit.
//  Feeds keypad/console decimal entry into the CPU datapath (e.g. 0..9999 -> 14-bit operand).
// PARAMETERS
//  DIGITS  4   number of BCD digits in DEC_IN (>=1)
//  BIN_W   14  result width; must satisfy 2^BIN_W > 10^DIGITS-1
// PORTS
//  CLK      in   1           system clock; all state changes on rising edge
//  RESET    in   1           synchronous, active-high reset
//  START    in   1           request conversion; sampled only in IDLE
//  DEC_IN   in   4*DIGITS    packed BCD operand; latched on accepted START
//  BUSY     out  1           high while a conversion is in progress
//  DONE     out  1           one-cycle pulse: BIN_OUT/ERR updated this cycle
//  BIN_OUT  out  BIN_W       binary result; holds until next completion
//  ERR      out  1           invalid-BCD flag (see CONFIGURATION); holds until next completion
// BEHAVIOUR
//  Reset: state=IDLE, BUSY=0, DONE=0, BIN_OUT=0, ERR=0, acc=0, digit counter=0.
//  RESET mid-conversion aborts: no DONE, BIN_OUT/ERR forced to 0.
//  States: IDLE, CONV.
//   IDLE: START=1 at edge E0 -> latch DEC_IN into shift reg, acc=0, cnt=DIGITS-1, go CONV, BUSY=1.
//   CONV: each edge acc <= acc*10 + nibble[cnt], cnt <= cnt-1.
//         On edge processing nibble 0 (edge E0+DIGITS): BIN_OUT <= final acc, DONE <= 1, BUSY <= 0, go IDLE.
//  Latency: START sampled at E0 -> DONE high in cycle after edge E0+DIGITS (DIGITS cycles, 4 by default).
//  BUSY is high for exactly DIGITS cycles; DONE is high for exactly 1 cycle, never together with BUSY.
//  START while BUSY=1 is ignored; DEC_IN changes after E0 have no effect.
//  START=1 in the DONE cycle is accepted (state is IDLE): back-to-back conversions, no dead cycle.
//  START held high continuously -> a new conversion starts every DIGITS+1 cycles.
//  Arithmetic: acc*10 = (acc<<3)+(acc<<1), computed in BIN_W+4 bits, truncated to BIN_W on assign.
//   Valid BCD input never truncates.
//  DONE is a registered output, cleared on the edge after it is asserted.
// CONFIGURATION
//  Macro DEC_BIN_BCD_CHECK_EN:
//   defined: on accepted START, flag any nibble > 9; conversion still takes DIGITS cycles.
//            At completion ERR <= flag; if flag=1, BIN_OUT <= 0.
//   undefined: ERR tied to 0; nibbles > 9 weighted as-is (A=10..F=15), result truncated to BIN_W.
//   The port list is identical in both builds.
// TESTING
//  1. DEC_IN=16'h9999, START 1 cycle -> BUSY high 4 cycles, then DONE 1 cycle with BIN_OUT=14'd9999, ERR=0.
//  2. DEC_IN=16'h0000 -> BIN_OUT=0; then DEC_IN=16'h1000 -> BIN_OUT=1000; then 16'h0001 -> 1.
//  3. START with 16'h0042; pulse START with 16'h1234 two cycles later -> single DONE, BIN_OUT=42; no second DONE.
//  4. START held high with DEC_IN=16'h0507 across DONE of 16'h0042 -> DONE(42); 5 cycles later DONE(507).
//  5. RESET asserted in 2nd CONV cycle of 16'h8765 -> next cycle BUSY=0, BIN_OUT=0, ERR=0; no DONE pulse.
//  6. DEC_IN=16'h12A4: with DEC_BIN_BCD_CHECK_EN -> DONE, ERR=1, BIN_OUT=0; without -> ERR=0, BIN_OUT=1304.

Source files
------------

// File: rtl/dec_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock MSD first (acc = acc*10 + digit).
// Optional invalid-nibble detection enabled by defining DEC_BIN_BCD_CHECK_EN.
module dec_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   DEC_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [BIN_W-1:0]      BIN_OUT,
  output logic                  ERR
);

  localparam int DW    = 4 * DIGITS;
  localparam int AW    = BIN_W + 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [AW-1:0]     acc_ext;
  logic [BIN_W-1:0]  step;
  logic [3:0]        nib;

  // Digits are consumed from the top of the shift register, MSD first.
  assign nib     = shreg_q[DW-1 -: 4];
  assign acc_ext = {4'b0000, acc_q};
  assign step    = BIN_W'((acc_ext << 3) + (acc_ext << 1) + AW'(nib));

`ifdef DEC_BIN_BCD_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
  logic in_bad;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (DEC_IN[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
`ifdef DEC_BIN_BCD_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CONV;
          shreg_d = DEC_IN;
          acc_d   = '0;
          cnt_d   = CNT_W'(DIGITS - 1);
`ifdef DEC_BIN_BCD_CHECK_EN
          bad_d   = in_bad;
`endif
        end
      end
      S_CONV: begin
        acc_d   = step;
        shreg_d = shreg_q << 4;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          bin_d   = step;
`ifdef DEC_BIN_BCD_CHECK_EN
          err_d   = bad_q;
          if (bad_q) bin_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bin_q   <= '0;
`ifdef DEC_BIN_BCD_CHECK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
`ifdef DEC_BIN_BCD_CHECK_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  assign BUSY    = (state_q == S_CONV);
  assign DONE    = done_q;
  assign BIN_OUT = bin_q;
`ifdef DEC_BIN_BCD_CHECK_EN
  assign ERR     = err_q;
`else
  assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_dec_bin_seq.sv
// Bench for dec_bin_seq: per-cycle arithmetic reference model plus directed scenarios.
module tb_dec_bin_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [15:0] DEC_IN;
  logic        BUSY;
  logic        DONE;
  logic [13:0] BIN_OUT;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dec_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .DEC_IN  (DEC_IN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .BIN_OUT (BIN_OUT),
    .ERR     (ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of the digit string, reduced mod 2^14.
  function automatic void model_conv(input logic [15:0] d, output logic [13:0] v, output logic e);
    int acc;
    logic [3:0] n;
    acc = 0;
    e   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      n = d[4*i +: 4];
      if (n > 4'd9) e = 1'b1;
      acc = acc * 10 + int'(n);
    end
    v = acc[13:0];
`ifdef DEC_BIN_BCD_CHECK_EN
    if (e) v = '0;
`else
    e = 1'b0;
`endif
  endfunction

  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic [13:0] m_bin = '0, m_pend = '0;
  logic        m_err = 1'b0, m_perr = 1'b0;
  bit          m_live = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_rem = 0; m_done = 1'b0; m_bin = '0; m_err = 1'b0; m_live = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1; m_bin = m_pend; m_err = m_perr;
        end
      end else if (START) begin
        m_rem = 4;
        model_conv(DEC_IN, m_pend, m_perr);
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      check("model_busy", BUSY, (m_rem > 0));
      check("model_done", DONE, m_done);
      check("model_bin",  BIN_OUT, m_bin);
      check("model_err",  ERR, m_err);
    end
  end

  task automatic run_one(input logic [15:0] d, input logic [13:0] exp_bin,
                         input logic exp_err, input string name);
    int busy_n = 0;
    bit seen   = 1'b0;
    DEC_IN = d;
    START  = 1'b1;
    @(negedge CLK);
    START  = 1'b0;
    DEC_IN = 16'hFFFF;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (BUSY) busy_n++;
      if (DONE) seen = 1'b1;
      else @(negedge CLK);
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_bin"}, BIN_OUT, exp_bin);
    check({name, "_err"}, ERR, exp_err);
    check({name, "_busy_cycles"}, busy_n, 4);
  endtask

  initial begin
    int dn, gap;
    bit seen;
    RESET = 1'b1; START = 1'b0; DEC_IN = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_bin",  BIN_OUT, 0);
    check("reset_err",  ERR, 0);
    RESET = 1'b0;
    @(negedge CLK);

    run_one(16'h9999, 14'd9999, 1'b0, "t1_9999");
    @(negedge CLK);
    run_one(16'h0000, 14'd0,    1'b0, "t2_0000");
    run_one(16'h1000, 14'd1000, 1'b0, "t2_1000");
    run_one(16'h0001, 14'd1,    1'b0, "t2_0001");
    @(negedge CLK);

    // Second START two cycles into a conversion must be ignored.
    DEC_IN = 16'h0042; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    DEC_IN = 16'h1234; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) begin
        dn++;
        check("t3_bin", BIN_OUT, 42);
      end
      @(negedge CLK);
    end
    check("t3_done_count", dn, 1);

    // START held high: back-to-back conversions DIGITS+1 cycles apart.
    DEC_IN = 16'h0042; START = 1'b1;
    @(negedge CLK);
    DEC_IN = 16'h0507;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (DONE) seen = 1'b1;
      else @(negedge CLK);
    end
    check("t4_first_done", seen, 1);
    check("t4_first_bin", BIN_OUT, 42);
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      gap++;
      if (DONE) seen = 1'b1;
    end
    START = 1'b0;
    check("t4_second_done", seen, 1);
    check("t4_gap", gap, 5);
    check("t4_second_bin", BIN_OUT, 507);
    @(negedge CLK);

    // Reset in the second CONV cycle aborts the conversion.
    DEC_IN = 16'h8765; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("t5_busy", BUSY, 0);
    check("t5_done", DONE, 0);
    check("t5_bin",  BIN_OUT, 0);
    check("t5_err",  ERR, 0);
    RESET = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    check("t5_no_done", dn, 0);

`ifdef DEC_BIN_BCD_CHECK_EN
    run_one(16'h12A4, 14'd0,    1'b1, "t6_12A4");
`else
    run_one(16'h12A4, 14'd1304, 1'b0, "t6_12A4");
`endif
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
